// File: rtl/apb_bridge_fsm_if.sv
// AHB-side / APB-side signal bundle for apb_bridge_fsm.
// Pready exists only when APB_WAIT_EN is defined.
interface apb_bridge_fsm_if #(
  parameter int WIDTH  = 32,
  parameter int SLAVES = 4
);
  logic              Hvalid;
  logic [WIDTH-1:0]  Haddr;
  logic              Hwrite;
  logic [WIDTH-1:0]  Hwdata;
  logic [WIDTH-1:0]  Prdata_in;
`ifdef APB_WAIT_EN
  logic              Pready;
`endif
  logic [WIDTH-1:0]  Paddr_in;
  logic              Pwrite_in;
  logic [WIDTH-1:0]  Pwdata_in;
  logic [SLAVES-1:0] Pselx_in;
  logic              Penable_in;
  logic              Hreadyout;
  logic              Hresp;
  logic [WIDTH-1:0]  Hrdata;

  modport master (
    output Hvalid, Haddr, Hwrite, Hwdata, Prdata_in,
`ifdef APB_WAIT_EN
    output Pready,
`endif
    input  Paddr_in, Pwrite_in, Pwdata_in, Pselx_in, Penable_in,
    input  Hreadyout, Hresp, Hrdata
  );

  modport slave (
    input  Hvalid, Haddr, Hwrite, Hwdata, Prdata_in,
`ifdef APB_WAIT_EN
    input  Pready,
`endif
    output Paddr_in, Pwrite_in, Pwdata_in, Pselx_in, Penable_in,
    output Hreadyout, Hresp, Hrdata
  );
endinterface

// File: rtl/apb_bridge_fsm.sv
// AHB-to-APB bridge sequencer: SETUP/ENABLE sequencing, slave decode, AHB stall and error response.
// Optional APB_WAIT_EN: adds Pready and stretches ENABLE while Pready is low.
//
// state  | meaning
// IDLE   | no transfer in flight, ready for a new address phase
// WWAIT  | write accepted, capturing Hwdata
// SETUP  | APB setup phase, select asserted, enable low
// ENABLE | APB access phase, completes when Pready is high
// ERR1   | unmapped address, first ERROR cycle (stall)
// ERR2   | unmapped address, second ERROR cycle (ready)
module apb_bridge_fsm #(
  parameter int WIDTH  = 32,
  parameter int SLAVES = 4
) (
  input  logic             Hclk,
  input  logic             Hreset,
  apb_bridge_fsm_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, WWAIT, SETUP, ENABLE, ERR1, ERR2} state_t;

  state_t            state, state_nxt;
  logic [3:0]        haddr_idx, idx_q, idx_nxt;
  logic              pready, accept, unmapped, hready, hresp;
  logic [SLAVES-1:0] sel_dec;

  logic [WIDTH-1:0]  paddr_q, pwdata_q;
  logic              pwrite_q, penable_q;
  logic [SLAVES-1:0] psel_q;

`ifdef APB_WAIT_EN
  assign pready = bus.Pready;
`else
  assign pready = 1'b1;
`endif

  assign haddr_idx = bus.Haddr[WIDTH-1 -: 4];
  assign unmapped  = {1'b0, haddr_idx} >= 5'(SLAVES);

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    hready    = 1'b1;
    hresp     = 1'b0;
    state_nxt = state;
    unique case (state)
      IDLE:   hready = 1'b1;
      WWAIT:  hready = 1'b0;
      SETUP:  hready = 1'b0;
      ENABLE: hready = pready;
      ERR1:   begin hready = 1'b0; hresp = 1'b1; end
      ERR2:   begin hready = 1'b1; hresp = 1'b1; end
      default: hready = 1'b1;
    endcase

    // hready is only high where a new address phase may be taken
    accept = bus.Hvalid & hready;

    if (accept) begin
      if (unmapped)        state_nxt = ERR1;
      else if (bus.Hwrite) state_nxt = WWAIT;
      else                 state_nxt = SETUP;
    end else begin
      unique case (state)
        IDLE:    state_nxt = IDLE;
        WWAIT:   state_nxt = SETUP;
        SETUP:   state_nxt = ENABLE;
        ENABLE:  state_nxt = pready ? IDLE : ENABLE;
        ERR1:    state_nxt = ERR2;
        ERR2:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end

    idx_nxt = accept ? haddr_idx : idx_q;
    sel_dec = '0;
    for (int i = 0; i < SLAVES; i++) sel_dec[i] = (idx_nxt == 4'(i));
  end

  // APB outputs are registered from the next state so they line up with it
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      idx_q     <= '0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
    end else begin
      idx_q <= idx_nxt;
      if (accept) begin
        paddr_q  <= bus.Haddr;
        pwrite_q <= bus.Hwrite;
      end
      if (state == WWAIT) pwdata_q <= bus.Hwdata;
      psel_q    <= (state_nxt == SETUP || state_nxt == ENABLE) ? sel_dec : '0;
      penable_q <= (state_nxt == ENABLE);
    end
  end

  assign bus.Paddr_in   = paddr_q;
  assign bus.Pwrite_in  = pwrite_q;
  assign bus.Pwdata_in  = pwdata_q;
  assign bus.Pselx_in   = psel_q;
  assign bus.Penable_in = penable_q;
  assign bus.Hreadyout  = hready;
  assign bus.Hresp      = hresp;
  assign bus.Hrdata     = bus.Prdata_in;

endmodule

// File: tb/tb_apb_bridge_fsm.sv
// Scoreboard bench for apb_bridge_fsm: directed timing checks plus a back-to-back random run.
module tb_apb_bridge_fsm;
  localparam int WIDTH  = 32;
  localparam int SLAVES = 4;
  localparam logic [31:0] RD_KEY = 32'hDAFE_F01D;

  logic Hclk = 1'b0;
  logic Hreset;
  int   vectors = 0;
  int   miscompares = 0;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  sel;
    logic        err;
  } exp_t;
  exp_t sbq[$];

  apb_bridge_fsm_if #(.WIDTH(WIDTH), .SLAVES(SLAVES)) bus ();
  apb_bridge_fsm #(.WIDTH(WIDTH), .SLAVES(SLAVES)) dut (.Hclk(Hclk), .Hreset(Hreset), .bus(bus));

  always #5 Hclk = ~Hclk;

  // APB slave model: read data derived from the registered address
  assign bus.Prdata_in = bus.Paddr_in ^ RD_KEY;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void push_exp(input logic [31:0] a, input logic w, input logic [31:0] d);
    exp_t e;
    logic [3:0] idx;
    idx     = a[31:28];
    e.addr  = a;
    e.wr    = w;
    e.wdata = d;
    e.rdata = a ^ RD_KEY;
    e.err   = (idx >= 4'(SLAVES));
    e.sel   = e.err ? 4'b0000 : (4'b0001 << idx);
    sbq.push_back(e);
  endfunction

  task automatic cyc();
    @(posedge Hclk); #1;
  endtask

  task automatic smp();
    @(negedge Hclk);
  endtask

  // Called in a cycle where Hreadyout is high; returns at the negedge of the completing cycle
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d);
    int n;
    bus.Hvalid = 1'b1; bus.Haddr = a; bus.Hwrite = w;
    push_exp(a, w, d);
    cyc();
    bus.Hvalid = 1'b0; bus.Hwdata = d;
    n = 0;
    smp();
    while (!bus.Hreadyout && n < 20) begin smp(); n++; end
    if (n >= 20) check_val("xfer_timeout", 64'(n), 64'(0));
  endtask

  always @(negedge Hclk) begin
    if (!Hreset && bus.Hreadyout && (bus.Penable_in || bus.Hresp)) begin
      if (sbq.size() == 0) check_val("sb_extra", 1, 0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        check_val("sb_err", 64'(bus.Hresp), 64'(e.err));
        check_val("sb_sel", 64'(bus.Pselx_in), 64'(e.sel));
        if (!e.err) begin
          check_val("sb_addr", 64'(bus.Paddr_in), 64'(e.addr));
          check_val("sb_wr", 64'(bus.Pwrite_in), 64'(e.wr));
          if (e.wr) check_val("sb_wdata", 64'(bus.Pwdata_in), 64'(e.wdata));
          else      check_val("sb_rdata", 64'(bus.Hrdata), 64'(e.rdata));
        end
      end
    end
  end

  initial begin
    Hreset = 1'b1;
    bus.Hvalid = 1'b0; bus.Haddr = '0; bus.Hwrite = 1'b0; bus.Hwdata = '0;
`ifdef APB_WAIT_EN
    bus.Pready = 1'b1;
`endif
    repeat (2) @(posedge Hclk);
    smp();
    check_val("rst_sel", 64'(bus.Pselx_in), 0);
    check_val("rst_en", 64'(bus.Penable_in), 0);
    check_val("rst_ready", 64'(bus.Hreadyout), 1);
    check_val("rst_resp", 64'(bus.Hresp), 0);
    check_val("rst_addr", 64'(bus.Paddr_in), 0);
    Hreset = 1'b0;
    cyc();

    // read, 2-cycle latency
    bus.Hvalid = 1'b1; bus.Haddr = 32'h1000_0010; bus.Hwrite = 1'b0;
    push_exp(32'h1000_0010, 1'b0, 32'h0);
    smp(); check_val("rd_t0_ready", 64'(bus.Hreadyout), 1);
    cyc(); bus.Hvalid = 1'b0;
    smp();
    check_val("rd_t1_sel", 64'(bus.Pselx_in), 64'(4'b0010));
    check_val("rd_t1_en", 64'(bus.Penable_in), 0);
    check_val("rd_t1_ready", 64'(bus.Hreadyout), 0);
    check_val("rd_t1_addr", 64'(bus.Paddr_in), 64'(32'h1000_0010));
    cyc(); smp();
    check_val("rd_t2_en", 64'(bus.Penable_in), 1);
    check_val("rd_t2_ready", 64'(bus.Hreadyout), 1);
    check_val("rd_t2_rdata", 64'(bus.Hrdata), 64'(32'hCAFE_F00D));
    cyc(); smp();
    check_val("rd_idle_sel", 64'(bus.Pselx_in), 0);
    check_val("rd_idle_ready", 64'(bus.Hreadyout), 1);
    cyc();

    // write, 3-cycle latency
    bus.Hvalid = 1'b1; bus.Haddr = 32'h3000_0004; bus.Hwrite = 1'b1;
    push_exp(32'h3000_0004, 1'b1, 32'hA5A5_5A5A);
    cyc(); bus.Hvalid = 1'b0; bus.Hwdata = 32'hA5A5_5A5A;
    smp();
    check_val("wr_t1_ready", 64'(bus.Hreadyout), 0);
    check_val("wr_t1_sel", 64'(bus.Pselx_in), 0);
    check_val("wr_t1_dir", 64'(bus.Pwrite_in), 1);
    cyc(); bus.Hwdata = 32'h0;
    smp();
    check_val("wr_t2_sel", 64'(bus.Pselx_in), 64'(4'b1000));
    check_val("wr_t2_wdata", 64'(bus.Pwdata_in), 64'(32'hA5A5_5A5A));
    check_val("wr_t2_en", 64'(bus.Penable_in), 0);
    check_val("wr_t2_ready", 64'(bus.Hreadyout), 0);
    cyc(); smp();
    check_val("wr_t3_en", 64'(bus.Penable_in), 1);
    check_val("wr_t3_ready", 64'(bus.Hreadyout), 1);
    check_val("wr_t3_wdata", 64'(bus.Pwdata_in), 64'(32'hA5A5_5A5A));
    cyc();

    // back-to-back: write accepted in the read's ENABLE cycle
    bus.Hvalid = 1'b1; bus.Haddr = 32'h0000_0000; bus.Hwrite = 1'b0;
    push_exp(32'h0000_0000, 1'b0, 32'h0);
    cyc(); bus.Hvalid = 1'b0;
    smp(); check_val("b2b_t1_sel", 64'(bus.Pselx_in), 64'(4'b0001));
    cyc();
    bus.Hvalid = 1'b1; bus.Haddr = 32'h2000_0000; bus.Hwrite = 1'b1;
    push_exp(32'h2000_0000, 1'b1, 32'h1234_5678);
    smp();
    check_val("b2b_t2_en", 64'(bus.Penable_in), 1);
    check_val("b2b_t2_sel", 64'(bus.Pselx_in), 64'(4'b0001));
    cyc(); bus.Hvalid = 1'b0; bus.Hwdata = 32'h1234_5678;
    smp();
    check_val("b2b_t3_sel", 64'(bus.Pselx_in), 0);
    check_val("b2b_t3_en", 64'(bus.Penable_in), 0);
    check_val("b2b_t3_ready", 64'(bus.Hreadyout), 0);
    cyc(); smp();
    check_val("b2b_t4_sel", 64'(bus.Pselx_in), 64'(4'b0100));
    cyc(); smp();
    check_val("b2b_t5_ready", 64'(bus.Hreadyout), 1);
    cyc();

    // unmapped slave index
    bus.Hvalid = 1'b1; bus.Haddr = 32'h7000_0000; bus.Hwrite = 1'b0;
    push_exp(32'h7000_0000, 1'b0, 32'h0);
    cyc(); bus.Hvalid = 1'b0;
    smp();
    check_val("err_t1_resp", 64'(bus.Hresp), 1);
    check_val("err_t1_ready", 64'(bus.Hreadyout), 0);
    check_val("err_t1_sel", 64'(bus.Pselx_in), 0);
    cyc(); smp();
    check_val("err_t2_resp", 64'(bus.Hresp), 1);
    check_val("err_t2_ready", 64'(bus.Hreadyout), 1);
    check_val("err_t2_en", 64'(bus.Penable_in), 0);
    cyc(); smp();
    check_val("err_t3_resp", 64'(bus.Hresp), 0);
    cyc();

`ifdef APB_WAIT_EN
    // Pready low for three ENABLE cycles
    bus.Hvalid = 1'b1; bus.Haddr = 32'h0000_0020; bus.Hwrite = 1'b0;
    push_exp(32'h0000_0020, 1'b0, 32'h0);
    cyc(); bus.Hvalid = 1'b0;
    cyc(); bus.Pready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      smp();
      check_val("wait_en", 64'(bus.Penable_in), 1);
      check_val("wait_ready", 64'(bus.Hreadyout), 0);
      check_val("wait_sel", 64'(bus.Pselx_in), 64'(4'b0001));
      check_val("wait_addr", 64'(bus.Paddr_in), 64'(32'h0000_0020));
      cyc();
    end
    bus.Pready = 1'b1;
    smp(); check_val("wait_done", 64'(bus.Hreadyout), 1);
    cyc(); smp(); check_val("wait_idle_sel", 64'(bus.Pselx_in), 0);
    cyc();
`endif

    // reset during SETUP of a write
    bus.Hvalid = 1'b1; bus.Haddr = 32'h1000_0008; bus.Hwrite = 1'b1;
    push_exp(32'h1000_0008, 1'b1, 32'h55AA_55AA);
    cyc(); bus.Hvalid = 1'b0; bus.Hwdata = 32'h55AA_55AA;
    cyc(); smp();
    check_val("rstx_setup_sel", 64'(bus.Pselx_in), 64'(4'b0010));
    Hreset = 1'b1; #1;
    check_val("rstx_sel", 64'(bus.Pselx_in), 0);
    check_val("rstx_en", 64'(bus.Penable_in), 0);
    check_val("rstx_ready", 64'(bus.Hreadyout), 1);
    check_val("rstx_addr", 64'(bus.Paddr_in), 0);
    sbq.delete();
    smp(); Hreset = 1'b0;
    cyc();
    xfer(32'h0000_0044, 1'b0, 32'h0);

    // back-to-back random chain
    for (int i = 0; i < 10; i++) begin
      logic [31:0] a;
      a = {4'($urandom_range(0, 5)), 28'($urandom)};
      xfer(a, 1'($urandom_range(0, 1)), $urandom);
    end

    cyc(); smp();
    check_val("sb_drain", 64'(sbq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d vectors expected finish", vectors);
    $fatal(1, "timeout");
  end
endmodule
